// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver with mid-bit sampling, sticky error flags and
//            a first-word-fall-through byte FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]    c_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    c_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rx_meta;
    logic              r_rx_s;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_frame_err;
    logic              r_overrun;

    logic w_cnt_clr;
    logic w_shift;
    logic w_idx_clr;
    logic w_push;
    logic w_frame_set;
    logic w_pop;
    logic w_wr;
    logic w_overrun_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_idx_clr   = 1'b0;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rx_s) w_next = S_START;
            end
            S_START: begin
                if (r_cnt == c_HALF) begin
                    w_cnt_clr = 1'b1;
                    w_idx_clr = 1'b1;
                    w_next    = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_shift   = 1'b1;
                    if (r_bit_idx == 3'd7) w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_s) begin
                        w_push = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_frame_set = 1'b1;
                        w_next      = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_clr = 1'b1;
                if (r_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
            if (w_idx_clr) r_bit_idx <= '0;
            else if (w_shift) r_bit_idx <= r_bit_idx + 3'd1;
            if (w_shift) r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign empty         = (r_count == '0);
    assign full          = (r_count == c_DEPTH);
    assign w_pop         = rd_en & ~empty;
    assign w_wr          = w_push & (~full | w_pop);
    assign w_overrun_set = w_push & full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Set beats clear so an event coinciding with clr_err is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= (r_frame_err & ~clr_err) | w_frame_set;
            r_overrun   <= (r_overrun & ~clr_err) | w_overrun_set;
        end
    end

    assign rd_data   = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side endpoint for the serial stream produced by uart_tx. It oversamples the rx line, validates start and stop bits, and assembles 8N1 frames LSB-first. Good bytes go into an on-chip first-word-fall-through FIFO so a slow consumer can drain multi-byte messages. Framing and overrun conditions are reported through sticky flags.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit; must match uart_tx; even, >= 4
FIFO_DEPTH, 8, byte entries; power of two
CNT_W, 4, width of count output; must satisfy 2^CNT_W > FIFO_DEPTH (4 for default depth 8)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rd_en  input  1  pop head byte this cycle; ignored when empty
rd_data  output  8  FIFO head byte, valid while empty=0
empty  output  1  FIFO holds no bytes
full  output  1  FIFO holds FIFO_DEPTH bytes
count  output  CNT_W  number of bytes in FIFO
frame_err  output  1  sticky: frame with stop bit = 0 was received
overrun  output  1  sticky: good byte dropped because FIFO full
clr_err  input  1  clears frame_err and overrun

Behaviour:
- One clock (clk). Reset is synchronous, active-low on rst_n, sampled on the rising edge of clk.
- Reset values: empty=1, full=0, count=0, frame_err=0, overrun=0, rd_data=0, FSM=IDLE, pointers=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. Line-to-rx_s latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK. A bit counter runs 0..CLKS_PER_BIT-1.
- IDLE: when rx_s=0, go to START and clear the counter.
- START: when counter = CLKS_PER_BIT/2-1, check rx_s.
  - rx_s=0: go to DATA, clear counter and bit index.
  - rx_s=1: glitch; return to IDLE, no flags change.
- DATA: sample rx_s when counter = CLKS_PER_BIT-1. That is one bit-time after the previous sample, so sampling is mid-bit.
  - Shift the sample in LSB-first.
  - After bit index 7, go to STOP.
- STOP: sample rx_s when counter = CLKS_PER_BIT-1.
  - rx_s=1: push the byte (see FIFO rules), go to IDLE the same cycle.
  - rx_s=0: set frame_err, discard the byte, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- FIFO:
  - First-word-fall-through: rd_data = mem[rd_ptr] combinationally from registered storage.
  - Push is written at the stop-sample edge; empty falls on the following cycle.
  - Pop when rd_en=1 and empty=0: rd_ptr increments and count decrements.
  - Push when not full: write at wr_ptr, wr_ptr increments.
  - Push with full=1 and rd_en=1 in the same cycle: pop and push both occur; count is unchanged; no overrun.
  - Push with full=1 and rd_en=0: byte dropped, overrun set.
  - Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH); empty = (count==0).
- Sticky flags:
  - clr_err=1 clears both flags.
  - A set event in the same cycle as clr_err wins, so the flag stays 1.
- Reset mid-frame: FSM returns to IDLE, the partial byte is lost, and the FIFO is emptied. If rx is low when reset releases, the FSM enters START; the START glitch check rejects a line that is high at mid-bit.
- Throughput: back-to-back frames (stop bit immediately followed by a start bit) are received without loss.

Test Plan:
- Bench drives 8N1 at CLKS_PER_BIT=16: bytes 0x48,0x45,0x4C,0x4C,0x4F ("HELLO") with no reads -> count=5, full=0. Then rd_en held for 5 cycles -> rd_data sequence 48,45,4C,4C,4F, then empty=1, no flags set.
- rx pulsed low for 4 cycles, then high -> FSM back in IDLE, count=0, frame_err=0. A following frame 0xA5 is received correctly.
- Frame 0x55 with stop bit 0, line held low 40 cycles, then released -> frame_err=1, count=0, no extra bytes. Next frame 0xA3 -> count=1, rd_data=0xA3. Then clr_err pulse -> frame_err=0.
- Nine frames 0x01..0x09 with no reads -> full=1 after the 8th, overrun=1 after the 9th. Draining yields 01..08.
- FIFO full; rd_en=1 exactly on the stop-sample cycle of frame 0x77 -> overrun stays 0, count stays 8, 0x77 is the last byte out.
- rst_n low for 1 cycle during bit 3 of frame 0xFF with 2 bytes queued -> count=0, empty=1, flags 0. Next frame 0x3C -> count=1, rd_data=0x3C.
